// File: rtl/cwp_pkg.sv
// Shared types and the modular window-step helper for the CWP window controller.
package cwp_pkg;

    localparam int CWP_MAX_W = 5;

    typedef enum logic [2:0] {
        OP_SAVE    = 3'd0,
        OP_RESTORE = 3'd1,
        OP_TRAP    = 3'd2,
        OP_RETT    = 3'd3,
        OP_WRCWP   = 3'd4
    } op_code_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EVAL,
        ST_RESP
    } state_e;

    // Explicit wrap compare so the step stays correct for non-power-of-two window counts.
    function automatic logic [CWP_MAX_W-1:0] cwp_step(input logic [CWP_MAX_W-1:0] cur,
                                                      input logic inc,
                                                      input int unsigned nwindows);
        logic [CWP_MAX_W-1:0] last;
        last = CWP_MAX_W'(nwindows - 1);
        if (inc)
            return (cur == last) ? '0 : cur + CWP_MAX_W'(1);
        else
            return (cur == '0) ? last : cur - CWP_MAX_W'(1);
    endfunction

endpackage

// File: rtl/cwp_window_ctrl_if.sv
// Operation/WIM bus of the CWP window controller; trap_cnt exists only with CWP_TRAP_CNT_EN.
interface cwp_window_ctrl_if #(
    parameter int NWINDOWS = 8,
    parameter int CWP_W    = 3
);
    logic                op_valid;
    logic                op_ready;
    logic [2:0]          op_code;
    logic [CWP_W+1:0]    op_cwp;
    logic                wim_we;
    logic [NWINDOWS-1:0] wim_wdata;
    logic [CWP_W-1:0]    cwp;
    logic [CWP_W-1:0]    cwp_plus1;
    logic [CWP_W-1:0]    cwp_minus1;
    logic [NWINDOWS-1:0] wim;
    logic                change_cwp2;
    logic                done;
    logic                ovf_trap;
    logic                unf_trap;
    logic                illegal;
`ifdef CWP_TRAP_CNT_EN
    logic [15:0]         trap_cnt;
`endif

    modport master (
        output op_valid, op_code, op_cwp, wim_we, wim_wdata,
        input  op_ready, cwp, cwp_plus1, cwp_minus1, wim, change_cwp2,
               done, ovf_trap, unf_trap, illegal
`ifdef CWP_TRAP_CNT_EN
        , input trap_cnt
`endif
    );

    modport slave (
        input  op_valid, op_code, op_cwp, wim_we, wim_wdata,
        output op_ready, cwp, cwp_plus1, cwp_minus1, wim, change_cwp2,
               done, ovf_trap, unf_trap, illegal
`ifdef CWP_TRAP_CNT_EN
        , output trap_cnt
`endif
    );

endinterface

// File: rtl/cwp_wim_check.sv
// Combinational target selection plus WIM / range check for the op being evaluated.
module cwp_wim_check
    import cwp_pkg::*;
#(
    parameter int NWINDOWS = 8,
    parameter int CWP_W    = 3
) (
    input  logic [2:0]          op_code,
    input  logic [CWP_W+1:0]    op_cwp,
    input  logic [CWP_W-1:0]    cwp_plus1,
    input  logic [CWP_W-1:0]    cwp_minus1,
    input  logic [NWINDOWS-1:0] wim,
    output logic [CWP_W-1:0]    target,
    output logic                ovf,
    output logic                unf,
    output logic                illegal,
    output logic                commit
);

    localparam logic [CWP_W+1:0] NW_LIMIT = (CWP_W+2)'(NWINDOWS);

    always_comb begin
        target  = cwp_minus1;
        ovf     = 1'b0;
        unf     = 1'b0;
        illegal = 1'b0;
        commit  = 1'b0;
        case (op_code)
            OP_SAVE: begin
                target = cwp_minus1;
                ovf    = wim[cwp_minus1];
                commit = !wim[cwp_minus1];
            end
            // Trap entry must always reach a window, so WIM is deliberately ignored.
            OP_TRAP: begin
                target = cwp_minus1;
                commit = 1'b1;
            end
            OP_RESTORE, OP_RETT: begin
                target = cwp_plus1;
                unf    = wim[cwp_plus1];
                commit = !wim[cwp_plus1];
            end
            OP_WRCWP: begin
                target  = op_cwp[CWP_W-1:0];
                illegal = (op_cwp >= NW_LIMIT);
                commit  = (op_cwp < NW_LIMIT);
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/cwp_window_ctrl.sv
// Current-window-pointer manager: IDLE -> EVAL -> RESP per op, with overflow/underflow/illegal flags.
// Optional macro CWP_TRAP_CNT_EN adds a saturating trap counter on bus.trap_cnt.
module cwp_window_ctrl
    import cwp_pkg::*;
#(
    parameter int NWINDOWS = 8,
    parameter int CWP_W    = $clog2(NWINDOWS)
) (
    input  logic               clk,
    input  logic               rst_n,
    cwp_window_ctrl_if.slave   bus
);

    state_e              state_q, state_d;
    logic [2:0]          op_code_q;
    logic [CWP_W+1:0]    op_cwp_q;
    logic [CWP_W-1:0]    cwp_q, target_q;
    logic [NWINDOWS-1:0] wim_q;
    logic                ovf_q, unf_q, ill_q, commit_q;
    logic                accept;
    logic [CWP_W-1:0]    plus1, minus1, chk_target;
    logic                chk_ovf, chk_unf, chk_ill, chk_commit;

    assign accept = bus.op_valid && (state_q == ST_IDLE);
    assign plus1  = CWP_W'(cwp_step(CWP_MAX_W'(cwp_q), 1'b1, NWINDOWS));
    assign minus1 = CWP_W'(cwp_step(CWP_MAX_W'(cwp_q), 1'b0, NWINDOWS));

    cwp_wim_check #(.NWINDOWS(NWINDOWS), .CWP_W(CWP_W)) u_check (
        .op_code    (op_code_q),
        .op_cwp     (op_cwp_q),
        .cwp_plus1  (plus1),
        .cwp_minus1 (minus1),
        .wim        (wim_q),
        .target     (chk_target),
        .ovf        (chk_ovf),
        .unf        (chk_unf),
        .illegal    (chk_ill),
        .commit     (chk_commit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_EVAL;
            ST_EVAL: state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // The check result is frozen at the end of EVAL, so a WIM write landing then cannot affect it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_code_q <= '0;
            op_cwp_q  <= '0;
            cwp_q     <= '0;
            target_q  <= '0;
            wim_q     <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            ill_q     <= 1'b0;
            commit_q  <= 1'b0;
        end else begin
            if (bus.wim_we) wim_q <= bus.wim_wdata;
            if (accept) begin
                op_code_q <= bus.op_code;
                op_cwp_q  <= bus.op_cwp;
            end
            if (state_q == ST_EVAL) begin
                target_q <= chk_target;
                ovf_q    <= chk_ovf;
                unf_q    <= chk_unf;
                ill_q    <= chk_ill;
                commit_q <= chk_commit;
            end
            if (state_q == ST_RESP && commit_q) cwp_q <= target_q;
        end
    end

    always_comb begin
        bus.op_ready    = (state_q == ST_IDLE);
        bus.done        = (state_q == ST_RESP);
        bus.ovf_trap    = (state_q == ST_RESP) && ovf_q;
        bus.unf_trap    = (state_q == ST_RESP) && unf_q;
        bus.illegal     = (state_q == ST_RESP) && ill_q;
        bus.change_cwp2 = (state_q == ST_EVAL) &&
                          ((op_code_q == OP_RESTORE) || (op_code_q == OP_RETT));
        bus.cwp         = cwp_q;
        bus.cwp_plus1   = plus1;
        bus.cwp_minus1  = minus1;
        bus.wim         = wim_q;
    end

`ifdef CWP_TRAP_CNT_EN
    logic [15:0] trap_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            trap_cnt_q <= '0;
        else if (state_q == ST_RESP && (ovf_q || unf_q) && trap_cnt_q != 16'hFFFF)
            trap_cnt_q <= trap_cnt_q + 16'd1;
    end

    assign bus.trap_cnt = trap_cnt_q;
`endif

endmodule

// File: tb/tb_cwp_window_ctrl.sv
// Scoreboard bench for cwp_window_ctrl: an 8-window instance plus a 6-window instance for odd wrap.
module tb_cwp_window_ctrl;
    import cwp_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cwp_window_ctrl_if #(.NWINDOWS(8), .CWP_W(3)) bus_a ();
    cwp_window_ctrl_if #(.NWINDOWS(6), .CWP_W(3)) bus_b ();

    cwp_window_ctrl #(.NWINDOWS(8), .CWP_W(3)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
    cwp_window_ctrl #(.NWINDOWS(6), .CWP_W(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

    logic       sel = 1'b0;
    logic       op_valid = 1'b0;
    logic       wim_we = 1'b0;
    logic [2:0] op_code = '0;
    logic [4:0] op_cwp = '0;
    logic [7:0] wim_data = '0;

    assign bus_a.op_valid  = op_valid & ~sel;
    assign bus_a.wim_we    = wim_we & ~sel;
    assign bus_a.op_code   = op_code;
    assign bus_a.op_cwp    = op_cwp;
    assign bus_a.wim_wdata = wim_data;
    assign bus_b.op_valid  = op_valid & sel;
    assign bus_b.wim_we    = wim_we & sel;
    assign bus_b.op_code   = op_code;
    assign bus_b.op_cwp    = op_cwp;
    assign bus_b.wim_wdata = wim_data[5:0];

    logic       done_m, ready_m, chg_m, ovf_m, unf_m, ill_m;
    logic [2:0] cwp_m, plus1_m, minus1_m;
    logic [7:0] wim_m;
    assign done_m   = sel ? bus_b.done        : bus_a.done;
    assign ready_m  = sel ? bus_b.op_ready    : bus_a.op_ready;
    assign chg_m    = sel ? bus_b.change_cwp2 : bus_a.change_cwp2;
    assign ovf_m    = sel ? bus_b.ovf_trap    : bus_a.ovf_trap;
    assign unf_m    = sel ? bus_b.unf_trap    : bus_a.unf_trap;
    assign ill_m    = sel ? bus_b.illegal     : bus_a.illegal;
    assign cwp_m    = sel ? bus_b.cwp         : bus_a.cwp;
    assign plus1_m  = sel ? bus_b.cwp_plus1   : bus_a.cwp_plus1;
    assign minus1_m = sel ? bus_b.cwp_minus1  : bus_a.cwp_minus1;
    assign wim_m    = sel ? {2'b00, bus_b.wim} : bus_a.wim;

    typedef struct {
        logic       ovf;
        logic       unf;
        logic       ill;
        logic [2:0] cwp;
        int         accept_edge;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         outstanding = 0;
    int         cycle_cnt = 0;
    bit         pending_cwp = 0;
    logic [2:0] pend_cwp_val = '0;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 12 && outstanding != 0; i++) @(negedge clk);
        checkOutput("completion_outstanding", outstanding, 0);
    endtask

    task automatic setWim(input logic [7:0] v);
        @(negedge clk);
        wim_we   = 1'b1;
        wim_data = v;
        @(negedge clk);
        wim_we = 1'b0;
        checkOutput("wim_write", wim_m, v);
    endtask

    // mode: 0 plain, 1 WIM write in accept cycle, 2 WIM write during EVAL, 3 op_valid held into EVAL
    task automatic applyStimulus(input logic [2:0] code, input logic [4:0] opc, input int mode,
                                 input logic [7:0] wd, input logic e_ovf, input logic e_unf,
                                 input logic e_ill, input logic [2:0] e_cwp, input logic e_chg);
        exp_t e;
        @(negedge clk);
        checkOutput("ready_idle", ready_m, 1);
        op_valid = 1'b1;
        op_code  = code;
        op_cwp   = opc;
        if (mode == 1) begin
            wim_we   = 1'b1;
            wim_data = wd;
        end
        @(posedge clk);
        #1;
        e.ovf = e_ovf;
        e.unf = e_unf;
        e.ill = e_ill;
        e.cwp = e_cwp;
        e.accept_edge = cycle_cnt;
        sb.push_back(e);
        outstanding++;
        @(negedge clk);
        if (mode != 3) op_valid = 1'b0;
        wim_we = 1'b0;
        if (mode == 2) begin
            wim_we   = 1'b1;
            wim_data = wd;
        end
        checkOutput("change_cwp2_eval", chg_m, e_chg);
        checkOutput("ready_eval", ready_m, 0);
        @(negedge clk);
        op_valid = 1'b0;
        wim_we   = 1'b0;
        waitIdle();
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (pending_cwp) begin
                checkOutput("cwp_commit", cwp_m, pend_cwp_val);
                pending_cwp = 0;
                outstanding--;
            end
            if (done_m === 1'b1) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_done", done_m, 0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("ovf_trap", ovf_m, e.ovf);
                    checkOutput("unf_trap", unf_m, e.unf);
                    checkOutput("illegal", ill_m, e.ill);
                    checkOutput("done_latency", cycle_cnt + 1 - e.accept_edge, 2);
                    pending_cwp  = 1;
                    pend_cwp_val = e.cwp;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (2) @(negedge clk);
        checkOutput("reset_done", done_m, 0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset_cwp", cwp_m, 0);
        checkOutput("reset_plus1", plus1_m, 1);
        checkOutput("reset_minus1", minus1_m, 7);
        checkOutput("reset_wim", wim_m, 8'h00);
        checkOutput("reset_ready", ready_m, 1);
        checkOutput("reset_chg", chg_m, 0);

        applyStimulus(OP_WRCWP,   5'd3, 0, 8'h00, 0, 0, 0, 3'd3, 0);
        setWim(8'h01);
        applyStimulus(OP_SAVE,    5'd0, 0, 8'h00, 0, 0, 0, 3'd2, 0);
        applyStimulus(OP_WRCWP,   5'd0, 0, 8'h00, 0, 0, 0, 3'd0, 0);
        setWim(8'h80);
        applyStimulus(OP_SAVE,    5'd0, 0, 8'h00, 1, 0, 0, 3'd0, 0);
        applyStimulus(OP_TRAP,    5'd0, 0, 8'h00, 0, 0, 0, 3'd7, 0);
        checkOutput("wrap_plus1", plus1_m, 0);
        checkOutput("wrap_minus1", minus1_m, 6);
        setWim(8'h01);
        applyStimulus(OP_RESTORE, 5'd0, 0, 8'h00, 0, 1, 0, 3'd7, 1);
        setWim(8'h00);
        applyStimulus(OP_RETT,    5'd0, 0, 8'h00, 0, 0, 0, 3'd0, 1);
        applyStimulus(OP_WRCWP,   5'd9, 0, 8'h00, 0, 0, 1, 3'd0, 0);
        applyStimulus(OP_WRCWP,   5'd5, 0, 8'h00, 0, 0, 0, 3'd5, 0);
        applyStimulus(OP_WRCWP,   5'd8, 0, 8'h00, 0, 0, 1, 3'd5, 0);
        applyStimulus(3'd5,       5'd1, 0, 8'h00, 0, 0, 1, 3'd5, 0);
        applyStimulus(3'd7,       5'd2, 0, 8'h00, 0, 0, 1, 3'd5, 0);
        applyStimulus(OP_WRCWP,   5'd3, 0, 8'h00, 0, 0, 0, 3'd3, 0);
        applyStimulus(OP_SAVE,    5'd0, 1, 8'h04, 1, 0, 0, 3'd3, 0);
        setWim(8'h00);
        applyStimulus(OP_SAVE,    5'd0, 2, 8'h04, 0, 0, 0, 3'd2, 0);
        checkOutput("wim_eval_write", wim_m, 8'h04);
        setWim(8'h00);
        applyStimulus(OP_RESTORE, 5'd0, 3, 8'h00, 0, 0, 0, 3'd3, 1);
        setWim(8'hFF);
        applyStimulus(OP_TRAP,    5'd0, 0, 8'h00, 0, 0, 0, 3'd2, 0);
        applyStimulus(OP_RETT,    5'd0, 0, 8'h00, 0, 1, 0, 3'd2, 1);
        setWim(8'h00);

        applyStimulus(OP_WRCWP,   5'd4, 0, 8'h00, 0, 0, 0, 3'd4, 0);
        @(negedge clk);
        op_valid = 1'b1;
        op_code  = OP_RESTORE;
        @(posedge clk);
        #1;
        @(negedge clk);
        op_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        checkOutput("abort_cwp", cwp_m, 0);
        checkOutput("abort_done", done_m, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("abort_cwp_after", cwp_m, 0);
        checkOutput("abort_ready", ready_m, 1);

        sel = 1'b1;
        @(negedge clk);
        checkOutput("nw6_reset_minus1", minus1_m, 5);
        applyStimulus(OP_WRCWP,   5'd5, 0, 8'h00, 0, 0, 0, 3'd5, 0);
        checkOutput("nw6_plus1", plus1_m, 0);
        checkOutput("nw6_minus1", minus1_m, 4);
        applyStimulus(OP_RESTORE, 5'd0, 0, 8'h00, 0, 0, 0, 3'd0, 1);
        applyStimulus(OP_WRCWP,   5'd6, 0, 8'h00, 0, 0, 1, 3'd0, 0);
        applyStimulus(OP_SAVE,    5'd0, 0, 8'h00, 0, 0, 0, 3'd5, 0);
        setWim(8'h10);
        applyStimulus(OP_SAVE,    5'd0, 0, 8'h00, 1, 0, 0, 3'd5, 0);

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cwp_window_ctrl.md
Name: cwp_window_ctrl

Overview:
Sequential current-window-pointer manager for the SPARC-style integer unit. It holds the CWP and WIM registers and executes SAVE, RESTORE, trap-entry, RETT and WRPSR window operations. It feeds the combinational new-CWP decode stage with the registered CWP and changeCWP2 context, and consumes the CWP+1 / CWP-1 values. It also flags window overflow, window underflow and illegal CWP writes.

Parameters:
NWINDOWS, 8, number of register windows; legal range 2..32, power of two not required.
CWP_W, 3, CWP width; must equal clog2(NWINDOWS).

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
op_valid  in  1  operation request
op_ready  out  1  high only in IDLE; request accepted when op_valid & op_ready
op_code  in  3  0=SAVE, 1=RESTORE, 2=TRAP, 3=RETT, 4=WRCWP; 5..7 reserved
op_cwp  in  CWP_W+2  WRCWP operand, sampled at accept
wim_we  in  1  WIM write strobe
wim_wdata  in  NWINDOWS  new WIM value
cwp  out  CWP_W  registered current window pointer
cwp_plus1  out  CWP_W  (cwp+1) mod NWINDOWS, combinational from cwp
cwp_minus1  out  CWP_W  (cwp-1) mod NWINDOWS, combinational from cwp
wim  out  NWINDOWS  registered window invalid mask
change_cwp2  out  1  high while a RESTORE or RETT is in EVAL; selects the increment path downstream
done  out  1  one-cycle completion pulse
ovf_trap  out  1  valid with done; SAVE target window invalid
unf_trap  out  1  valid with done; RESTORE or RETT target window invalid
illegal  out  1  valid with done; WRCWP value >= NWINDOWS, or reserved op_code

Behaviour:
- Reset values: cwp=0, wim=0, state=IDLE, done=0, all flags 0, change_cwp2=0, op_ready=1.
- FSM states: IDLE -> EVAL -> RESP -> IDLE.
  - IDLE: on accept, register op_code and op_cwp, then go to EVAL.
  - EVAL: compute the target and check it. Go to RESP.
  - RESP: done=1 with the flags, commit cwp if there is no fault, then go to IDLE.
- Latency: done is asserted exactly 2 cycles after the accept edge. Throughput is one op per 3 cycles.
- Targets:
  - SAVE and TRAP use cwp_minus1.
  - RESTORE and RETT use cwp_plus1.
  - WRCWP uses op_cwp.
- Wrap-around: cwp=0 minus1 gives NWINDOWS-1. cwp=NWINDOWS-1 plus1 gives 0. This holds for non-power-of-two NWINDOWS.
- Checks:
  - SAVE: ovf_trap = wim[target].
  - RESTORE and RETT: unf_trap = wim[target].
  - TRAP never checks WIM and always commits.
  - WRCWP: illegal if op_cwp >= NWINDOWS.
  - Reserved op_code: illegal=1, no commit.
- On any fault, cwp is left unchanged. Exactly one flag can be high per done.
- WIM writes:
  - Applied at any cycle, on the clock edge.
  - A write in the accept cycle is visible to that op's EVAL check.
  - A write during EVAL is not visible to the in-flight op.
- op_valid outside IDLE is ignored. It is not queued, and op_ready=0.
- Reset mid-operation (EVAL or RESP) aborts the op: no done pulse, and cwp returns to 0.

Optional Feature:
CWP_TRAP_CNT_EN
- Defined: adds output trap_cnt[15:0], a saturating count of done pulses with ovf_trap or unf_trap set. It is reset to 0 and holds at 0xFFFF.
- Undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Package cwp_pkg holds:
  - op_code enum: OP_SAVE, OP_RESTORE, OP_TRAP, OP_RETT, OP_WRCWP.
  - FSM state enum: ST_IDLE, ST_EVAL, ST_RESP.
  - A modular inc/dec helper function parameterised by NWINDOWS.
- One sub-module, cwp_wim_check: combinational target selection plus WIM and range check. It is instantiated once in EVAL.

Test Plan:
- Reset, with NWINDOWS=8: cwp=0, cwp_plus1=1, cwp_minus1=7, wim=0x00, op_ready=1.
- SAVE at cwp=3, wim=0x01: done 2 cycles after accept, no flags, cwp=2.
- SAVE at cwp=0, wim=0x80: ovf_trap=1, cwp stays 0. Then TRAP at cwp=0, wim=0x80: cwp=7, no flag.
- RESTORE at cwp=7, wim=0x01: unf_trap=1, change_cwp2=1 during EVAL, cwp stays 7. RETT with wim=0x00 gives cwp=0.
- WRCWP 9: illegal=1, cwp unchanged. WRCWP 5: cwp=5. With NWINDOWS=6, RESTORE at cwp=5 gives cwp=0.
- Same-cycle and abort cases:
  - wim_we=0x04 in the accept cycle of a SAVE at cwp=3: ovf_trap=1.
  - rst_n low during EVAL: no done, cwp=0.
  - op_valid held in EVAL: ignored.
